// File: rtl/lane_os_tx.sv
// lane_os_tx: per-lane ordered-set generator (logical idle, TS1, TS2) feeding
// a registered running-disparity 8b/10b encoder one stage behind the bytes.
module lane_os_tx (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  ost,
  input  logic        en_n,
  input  logic [39:0] ts1,
  input  logic [39:0] ts2,
  output logic [7:0]  rxdata,
  output logic        rxdatak,
  output logic        rxvalid,
  output logic [9:0]  sym10,
  output logic        disp
);
  // state  | meaning
  // M_NONE | nothing transmitted, rxvalid=0, sidx parked at 0
  // M_IDLE | logical idle (00, K=0) every cycle, sidx parked at 0
  // M_TS1  | TS1 set in progress, sidx walks 0..15
  // M_TS2  | TS2 set in progress, sidx walks 0..15
  typedef enum logic [1:0] {M_NONE, M_IDLE, M_TS1, M_TS2} mode_t;

  mode_t       mode;
  mode_t       req;
  mode_t       nxt;
  logic [3:0]  sidx;
  logic [39:0] ts_sel;
  logic [7:0]  ts_byte;
  logic        ts_k;

  logic [4:0]  dx;
  logic [2:0]  dy;
  logic        k28;
  logic        k_alt;
  logic        six_unbal;
  logic        four_unbal;
  logic        rd_mid;
  logic        alt7;
  logic        enc_disp;
  logic [5:0]  six;
  logic [3:0]  four;
  logic [9:0]  enc_sym;

  // 5b/6b code in abcdei order (a = MSB) for the RD- column.
  function automatic logic [5:0] enc6(input logic [4:0] v);
    logic [5:0] r;
    case (v)
      5'd0:  r = 6'b100111;
      5'd1:  r = 6'b011101;
      5'd2:  r = 6'b101101;
      5'd3:  r = 6'b110001;
      5'd4:  r = 6'b110101;
      5'd5:  r = 6'b101001;
      5'd6:  r = 6'b011001;
      5'd7:  r = 6'b111000;
      5'd8:  r = 6'b111001;
      5'd9:  r = 6'b100101;
      5'd10: r = 6'b010101;
      5'd11: r = 6'b110100;
      5'd12: r = 6'b001101;
      5'd13: r = 6'b101100;
      5'd14: r = 6'b011100;
      5'd15: r = 6'b010111;
      5'd16: r = 6'b011011;
      5'd17: r = 6'b100011;
      5'd18: r = 6'b010011;
      5'd19: r = 6'b110010;
      5'd20: r = 6'b001011;
      5'd21: r = 6'b101010;
      5'd22: r = 6'b011010;
      5'd23: r = 6'b111010;
      5'd24: r = 6'b110011;
      5'd25: r = 6'b100110;
      5'd26: r = 6'b010110;
      5'd27: r = 6'b110110;
      5'd28: r = 6'b001110;
      5'd29: r = 6'b101110;
      5'd30: r = 6'b011110;
      default: r = 6'b101011;
    endcase
    return r;
  endfunction

  // A new request is only honoured between sets or when not sending a set.
  always_comb begin
    case (ost)
      6'd1:    req = M_IDLE;
      6'd2:    req = M_TS1;
      6'd3:    req = M_TS2;
      default: req = M_NONE;
    endcase
    nxt = mode;
    if (sidx == 4'd0 || mode == M_NONE || mode == M_IDLE) nxt = req;
  end

  always_comb begin
    ts_sel  = (nxt == M_TS2) ? ts2 : ts1;
    ts_byte = (nxt == M_TS2) ? 8'h45 : 8'h4A;
    ts_k    = 1'b0;
    case (sidx)
      4'd0: begin
        ts_byte = 8'hBC;
        ts_k    = 1'b1;
      end
      4'd1: begin
        ts_byte = ts_sel[7:0];
        ts_k    = (ts_sel[7:0] == 8'hF7);
      end
      4'd2: begin
        ts_byte = ts_sel[15:8];
        ts_k    = (ts_sel[15:8] == 8'hF7);
      end
      4'd3:    ts_byte = ts_sel[23:16];
      4'd4:    ts_byte = ts_sel[31:24];
      4'd5:    ts_byte = ts_sel[39:32];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode    <= M_NONE;
      sidx    <= 4'd0;
      rxdata  <= 8'h00;
      rxdatak <= 1'b0;
      rxvalid <= 1'b0;
    end else if (en_n) begin
      mode    <= M_NONE;
      sidx    <= 4'd0;
      rxdata  <= 8'h00;
      rxdatak <= 1'b0;
      rxvalid <= 1'b0;
    end else begin
      mode <= nxt;
      case (nxt)
        M_TS1, M_TS2: begin
          rxdata  <= ts_byte;
          rxdatak <= ts_k;
          rxvalid <= 1'b1;
          sidx    <= sidx + 4'd1;
        end
        M_IDLE: begin
          rxdata  <= 8'h00;
          rxdatak <= 1'b0;
          rxvalid <= 1'b1;
          sidx    <= 4'd0;
        end
        default: begin
          rxdata  <= 8'h00;
          rxdatak <= 1'b0;
          rxvalid <= 1'b0;
          sidx    <= 4'd0;
        end
      endcase
    end
  end

  // K codes other than K28.y / Kx.7 fall through to their D encoding.
  always_comb begin
    dx    = rxdata[4:0];
    dy    = rxdata[7:5];
    k28   = rxdatak && (dx == 5'd28);
    k_alt = k28 || (rxdatak && dy == 3'd7 &&
            (dx == 5'd23 || dx == 5'd27 || dx == 5'd29 || dx == 5'd30));

    six       = k28 ? 6'b001111 : enc6(dx);
    six_unbal = ($countones(six) != 3);
    rd_mid    = disp ^ six_unbal;
    if (disp && (six_unbal || dx == 5'd7)) six = ~six;

    four_unbal = (dy == 3'd0 || dy == 3'd4 || dy == 3'd7);
    alt7 = k_alt ||
           (!rd_mid && (dx == 5'd17 || dx == 5'd18 || dx == 5'd20)) ||
           (rd_mid && (dx == 5'd11 || dx == 5'd13 || dx == 5'd14));
    case (dy)
      3'd0:    four = 4'b1011;
      3'd1:    four = 4'b1001;
      3'd2:    four = 4'b0101;
      3'd3:    four = 4'b1100;
      3'd4:    four = 4'b1101;
      3'd5:    four = 4'b1010;
      3'd6:    four = 4'b0110;
      default: four = alt7 ? 4'b0111 : 4'b1110;
    endcase
    if (rd_mid && (four_unbal || dy == 3'd3)) four = ~four;
    // K28 uses the complementary form of the neutral fghj groups.
    if (k28 && !rd_mid && (dy == 3'd1 || dy == 3'd2 || dy == 3'd5 || dy == 3'd6))
      four = ~four;

    enc_disp = rd_mid ^ four_unbal;
    enc_sym  = {four[0], four[1], four[2], four[3],
                six[0], six[1], six[2], six[3], six[4], six[5]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sym10 <= 10'h000;
      disp  <= 1'b0;
    end else if (rxvalid) begin
      sym10 <= enc_sym;
      disp  <= enc_disp;
    end
  end

endmodule

// File: tb/tb_lane_os_tx.sv
// Bench for lane_os_tx: stimulus queues expected symbols, a negedge monitor
// pops them on rxvalid and checks the encoded stream one cycle later.
module tb_lane_os_tx;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  ost;
  logic        en_n;
  logic [39:0] ts1;
  logic [39:0] ts2;
  logic [7:0]  rxdata;
  logic        rxdatak;
  logic        rxvalid;
  logic [9:0]  sym10;
  logic        disp;

  localparam logic [39:0] TS_A = 40'h08_02_04_F7_F7;
  localparam logic [39:0] TS_B = 40'h3C_FC_F7_EB_F1;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];
  logic [9:0]  m_last;
  logic        m_rd;
  logic [8:0]  m_e;
  logic [9:0]  m_c;

  lane_os_tx dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ost     (ost),
    .en_n    (en_n),
    .ts1     (ts1),
    .ts2     (ts2),
    .rxdata  (rxdata),
    .rxdatak (rxdatak),
    .rxvalid (rxvalid),
    .sym10   (sym10),
    .disp    (disp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] rev10(input logic [9:0] c);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = c[9-i];
    return r;
  endfunction

  // Hand-written 8b/10b codes, written abcdei_fghj in transmission order.
  function automatic logic [9:0] ref_code(input logic [8:0] s, input logic rd);
    logic [9:0] c;
    case (s)
      {1'b1, 8'hBC}: c = rd ? 10'b110000_0101 : 10'b001111_1010;
      {1'b1, 8'hF7}: c = rd ? 10'b000101_0111 : 10'b111010_1000;
      {1'b0, 8'h04}: c = rd ? 10'b001010_1011 : 10'b110101_0100;
      {1'b0, 8'h02}: c = rd ? 10'b010010_1011 : 10'b101101_0100;
      {1'b0, 8'h08}: c = rd ? 10'b000110_1011 : 10'b111001_0100;
      {1'b0, 8'h4A}: c = 10'b010101_0101;
      {1'b0, 8'h45}: c = 10'b101001_0101;
      {1'b0, 8'h00}: c = rd ? 10'b011000_1011 : 10'b100111_0100;
      {1'b0, 8'hF1}: c = rd ? 10'b100011_0001 : 10'b100011_0111;
      {1'b0, 8'hEB}: c = rd ? 10'b110100_1000 : 10'b110100_1110;
      {1'b0, 8'hF7}: c = rd ? 10'b000101_1110 : 10'b111010_0001;
      {1'b0, 8'hFC}: c = rd ? 10'b001110_0001 : 10'b001110_1110;
      {1'b0, 8'h3C}: c = 10'b001110_1001;
      default:       c = 10'b000000_0000;
    endcase
    return c;
  endfunction

  task automatic push_ts(input logic [39:0] t, input logic [7:0] id, input int first, input int last);
    logic [7:0] b;
    logic       k;
    for (int s = first; s <= last; s++) begin
      if (s == 0) begin
        b = 8'hBC;
        k = 1'b1;
      end else if (s <= 5) begin
        b = t[8*(s-1) +: 8];
        k = (s <= 2) && (b == 8'hF7);
      end else begin
        b = id;
        k = 1'b0;
      end
      exp_q.push_back({k, b});
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(9'h000);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      m_last = 10'h000;
      m_rd   = 1'b0;
    end else begin
      chk("sym10", sym10, m_last);
      chk("disp", {9'd0, disp}, {9'd0, m_rd});
      if (rxvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_symbol: got k=%b data=%h with nothing expected", rxdatak, rxdata);
        end else begin
          m_e = exp_q.pop_front();
          chk("symbol", {1'b0, rxdatak, rxdata}, {1'b0, m_e});
          m_c    = ref_code(m_e, m_rd);
          m_last = rev10(m_c);
          m_rd   = m_rd ^ ($countones(m_c) != 5);
        end
      end else begin
        chk("idle_bus", {1'b0, rxdatak, rxdata}, 10'h000);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    en_n    = 1'b0;
    ost     = 6'd0;
    ts1     = 40'd0;
    ts2     = 40'd0;
    repeat (3) step();
    chk("rst_rxdata", {2'b0, rxdata}, 10'h000);
    chk("rst_rxdatak", {9'd0, rxdatak}, 10'h000);
    chk("rst_rxvalid", {9'd0, rxvalid}, 10'h000);
    chk("rst_sym10", sym10, 10'h000);
    chk("rst_disp", {9'd0, disp}, 10'h000);
    reset_n = 1'b1;
    repeat (3) begin
      step();
      chk("post_rst_rxvalid", {9'd0, rxvalid}, 10'h000);
    end

    // Three TS1 sets, switch to TS2 at sidx=7 of the third.
    ts1 = TS_A;
    ts2 = TS_A;
    ost = 6'd2;
    repeat (3) push_ts(TS_A, 8'h4A, 0, 15);
    push_ts(TS_A, 8'h45, 0, 15);
    step();
    step();
    chk("first_com_sym10", sym10, 10'h17C);
    chk("first_com_disp", {9'd0, disp}, 10'h001);
    repeat (37) step();
    ost = 6'd3;
    repeat (25) step();

    // Logical idle then TS1 starts at COM.
    ost = 6'd1;
    push_idle(5);
    step();
    step();
    chk("idle_sym10", sym10, 10'h0B9);
    chk("idle_disp", {9'd0, disp}, 10'h000);
    repeat (3) step();
    ost = 6'd2;
    push_ts(TS_A, 8'h4A, 0, 8);
    step();
    step();
    chk("idle_to_com_sym10", sym10, 10'h17C);
    repeat (7) step();

    // Electrical idle mid-set, then restart with a new TS1 payload.
    en_n = 1'b1;
    repeat (4) begin
      step();
      chk("eidle_rxvalid", {9'd0, rxvalid}, 10'h000);
    end
    ts1  = TS_B;
    en_n = 1'b0;
    push_ts(TS_B, 8'h4A, 0, 15);
    repeat (16) step();

    // Reset in the middle of a set; next set starts at COM from RD-.
    push_ts(TS_B, 8'h4A, 0, 4);
    repeat (5) step();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    ost     = 6'd0;
    #1;
    chk("midrst_rxvalid", {9'd0, rxvalid}, 10'h000);
    chk("midrst_sym10", sym10, 10'h000);
    chk("midrst_disp", {9'd0, disp}, 10'h000);
    step();
    step();
    reset_n = 1'b1;
    step();
    ost = 6'd2;
    push_ts(TS_B, 8'h4A, 0, 15);
    step();
    step();
    chk("rst_com_sym10", sym10, 10'h17C);
    chk("rst_com_disp", {9'd0, disp}, 10'h001);
    repeat (14) step();

    ost = 6'd0;
    repeat (4) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_empty: got %0d pending symbols expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
